// File: rtl/data_mem_param_pkg.sv
// Shared definitions for the byte-lane data memory: default geometry and
// the controller state encoding.
package data_mem_param_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 7;

  // IDLE services read/write requests; CLEAR zero-fills the whole array.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem_param_byte_lane_merge.sv
// Byte-lane merge: takes lanes from new_word where byte_en is set and keeps
// old_word lanes elsewhere. Lane k covers bits [8k+7:8k].
module byte_lane_merge
  import data_mem_param_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  localparam int LANES  = DATA_W / 8
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [LANES-1:0]  byte_en,
  output logic [DATA_W-1:0] merged
);

  // Per-lane select between the stored and the incoming byte.
  // NOTE: the output is assigned a default first so every path drives it
  // and no latch is inferred.
  always_comb begin
    merged = old_word;
    for (int k = 0; k < LANES; k++) begin
      if (byte_en[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
  end

endmodule

// File: rtl/data_mem_param.sv
// Single-port word memory with per-byte write enables, 1-cycle registered
// reads and a whole-array zero fill that runs after reset and on a clear
// pulse. While filling, busy is high and all requests are dropped.
module data_mem_param
  import data_mem_param_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int LANES  = DATA_W / 8,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [ADDR_W-1:0] line_number,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [LANES-1:0]  byte_en,
  input  logic              clear,
  output logic [DATA_W-1:0] mem_out,
  output logic              rd_valid,
  output logic              busy
);

  // One extra bit keeps the terminal compare from aliasing on wrap-around.
  localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W + 1)'(DEPTH - 1);

  // Contents start defined in simulation, before the first reset fill.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  state_e            state, state_nxt;
  logic [ADDR_W:0]   fill_cnt, fill_cnt_nxt;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] merged;

  byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (mem[line_number]),
    .new_word (mem_in),
    .byte_en  (byte_en),
    .merged   (merged)
  );

  // Controller next-state and write-port steering.
  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = line_number;
    wr_data      = merged;
    case (state)
      IDLE: begin
        // A request in the same cycle as clear is serviced before the fill.
        rd_en = mem_read;
        wr_en = mem_write;
        if (clear) begin
          state_nxt    = CLEAR;
          fill_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        wr_en        = 1'b1;
        wr_addr      = fill_cnt[ADDR_W-1:0];
        wr_data      = '0;
        fill_cnt_nxt = fill_cnt + 1'b1;
        if (fill_cnt == FILL_LAST) state_nxt = IDLE;
      end
    endcase
  end

  // Controller state, fill counter and registered read outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      fill_cnt <= '0;
      mem_out  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      busy     <= (state_nxt == CLEAR);
      rd_valid <= rd_en;
      // Reads see the pre-write word when a write hits the same address.
      if (rd_en) mem_out <= mem[line_number];
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset branch; it is cleared by the fill sequence
  // so it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_addr] <= wr_data;
  end

endmodule

// File: doc/data_mem_param.md
DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 7, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have derived constant LANES = DATA_W/8, the number of byte lanes.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_in  input  DATA_W  write data.
REQ-007 SHALL have port line_number  input  ADDR_W  word address for read and write.
REQ-008 SHALL have port mem_read  input  1  read request.
REQ-009 SHALL have port mem_write  input  1  write request.
REQ-010 SHALL have port byte_en  input  LANES  per-lane write enable; bit k covers mem_in[8k+7:8k].
REQ-011 SHALL have port clear  input  1  single-cycle pulse requesting a whole-memory zero fill.
REQ-012 SHALL have port mem_out  output  DATA_W  registered read data.
REQ-013 SHALL have port rd_valid  output  1  high for one cycle when mem_out carries new read data.
REQ-014 SHALL have port busy  output  1  high while a zero fill is in progress; requests are refused.

Function
REQ-015 SHALL have a two-state controller: IDLE (service requests) and CLEAR (zero fill).
REQ-016 In IDLE with mem_write=1, SHALL write only the lanes whose byte_en bit is 1 at line_number; other lanes keep their value.
REQ-017 In IDLE with mem_read=1, SHALL load mem_out with the word at line_number on the same edge and assert rd_valid for the following cycle: 1-cycle latency.
REQ-018 When mem_read=0 or busy=1, mem_out SHALL hold its last value and rd_valid SHALL be 0.
REQ-019 With mem_read and mem_write both 1 at the same address, mem_out SHALL return the pre-write (old) word; the write still takes effect.
REQ-020 mem_write with byte_en=0 SHALL leave memory unchanged.
REQ-021 In IDLE, clear=1 SHALL move to CLEAR, reset the fill counter to 0, and assert busy from the next cycle.
REQ-022 If clear and mem_read/mem_write are asserted in the same IDLE cycle, the read/write SHALL be performed first; the fill starts on the next cycle.
REQ-023 In CLEAR, SHALL write zero to address fill_cnt each cycle and increment fill_cnt by 1.
REQ-024 When fill_cnt = DEPTH-1, SHALL write that last word, return to IDLE, and deassert busy the next cycle; a fill takes exactly DEPTH cycles.
REQ-025 In CLEAR, mem_read, mem_write and clear SHALL be ignored and no request SHALL be queued.
REQ-026 fill_cnt SHALL be ADDR_W+1 bits wide so the terminal compare cannot be aliased by wrap-around.

Reset
REQ-027 While reset=1: state <= CLEAR, fill_cnt <= 0, mem_out <= 0, rd_valid <= 0, busy <= 1.
REQ-028 After reset deasserts, the memory SHALL be zero-filled (DEPTH cycles) before busy falls.
REQ-029 Reset asserted mid-fill or mid-operation SHALL restart the fill from address 0.
REQ-030 The array SHALL also be zero-initialised for simulation so its contents are defined before the first reset.

Structure
REQ-031 The state encoding (IDLE, CLEAR) and the default DATA_W/ADDR_W values SHALL live in the shared package.
REQ-032 Byte-lane merging SHALL be a sub-module byte_lane_merge (old word, new word, byte_en -> merged word); everything else stays in data_mem_param.

Verification
REQ-033 Reset, then hold for 128 cycles (DATA_W=8, ADDR_W=7) -> busy high exactly 128 cycles; then a read of 0x05 -> mem_out=0x00, rd_valid=1 one cycle later.
REQ-034 DATA_W=32: write 0xAABBCCDD at 3 with byte_en=1111, then write 0x11223344 with byte_en=0101, then read 3 -> mem_out=0xAA22CC44.
REQ-035 Write 0x5A at 10, then read and write 0xA5 to 10 in the same cycle -> mem_out=0x5A; the next read returns 0xA5.
REQ-036 Write 0x77 at 127, pulse clear; read 127 during busy -> rd_valid stays 0; after busy falls, read 127 -> 0x00.
REQ-037 Assert reset at fill cycle 60 -> busy stays high a further 128 cycles after reset releases; all words read back 0.
REQ-038 Same-cycle clear and write of 0x33 at 0 -> write occurs, fill follows, busy high 128 cycles, word 0 reads back 0x00.
